// File: rtl/sudoku_pkg.sv
// Shared constants and types for the Sudoku play-phase drawing datapath.
// Command codes, grid geometry, sequencer states and the glyph ROM address map.
package sudoku_pkg;

    localparam int GRID_N       = 9;
    localparam int CELL         = 11;
    localparam int GLYPH_PIXELS = CELL * CELL;

    localparam logic [3:0] CMD_DIGIT_MAX = 4'd8;
    localparam logic [3:0] CMD_UP        = 4'd9;
    localparam logic [3:0] CMD_DOWN      = 4'd10;
    localparam logic [3:0] CMD_LEFT      = 4'd11;
    localparam logic [3:0] CMD_RIGHT     = 4'd12;
    localparam logic [3:0] CMD_CLEAR     = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLOT,
        DONE
    } state_t;

    typedef enum logic {
        MODE_GLYPH,
        MODE_CLEAR
    } draw_mode_t;

    // Glyphs are stored back to back, each one a raster of CELL x CELL pixels.
    function automatic logic [10:0] glyph_addr(input logic [3:0] glyph,
                                               input logic [3:0] px,
                                               input logic [3:0] py);
        return 11'(int'(glyph) * GLYPH_PIXELS + int'(py) * CELL + int'(px));
    endfunction

endpackage

// File: rtl/cell_plot_sequencer_if.sv
// Keyboard command handshake from the game control FSM into the cell plot sequencer.
// The control FSM is the master; the sequencer is the slave and owns cmd_ready.
interface cell_plot_sequencer_if;

    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_code, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_code, output cmd_ready);

endinterface

// File: rtl/glyph_raster_counter.sv
// px/py raster walk over one glyph cell, px inner, with last-pixel flag and ROM address.
// The counter parks on the last pixel until cleared for the next draw.
module glyph_raster_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [3:0]  glyph,
    output logic [3:0]  px,
    output logic [3:0]  py,
    output logic        last,
    output logic [10:0] rom_addr
);
    import sudoku_pkg::*;

    localparam logic [3:0] EDGE_MAX = 4'(CELL - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (step && !last) begin
            if (px == EDGE_MAX) begin
                px <= '0;
                py <= py + 4'd1;
            end else begin
                px <= px + 4'd1;
            end
        end
    end

    assign last     = (px == EDGE_MAX) && (py == EDGE_MAX);
    assign rom_addr = glyph_addr(glyph, px, py);

endmodule

// File: rtl/cell_plot_sequencer.sv
// Play-phase VGA write sequencer: cursor tracking, given-cell protection and
// streaming of one glyph (or background fill) into the selected Sudoku cell.
module cell_plot_sequencer #(
    parameter int         X0        = 8,
    parameter int         Y0        = 8,
    parameter int         CELL      = 11,
    parameter logic [2:0] BG_COLOUR = 3'b111
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    cell_plot_sequencer_if.slave        cmd_bus,
    input  logic [80:0]                 given_mask,
    output logic [10:0]                 rom_addr,
    input  logic [2:0]                  rom_data,
    output logic [7:0]                  x,
    output logic [6:0]                  y,
    output logic [2:0]                  colour,
    output logic                        plot,
    output logic                        busy,
    output logic                        done,
    output logic                        reject,
    output logic [3:0]                  cur_row,
    output logic [3:0]                  cur_col
);
    import sudoku_pkg::*;

    if (CELL != sudoku_pkg::CELL) begin : g_cell_check
        $error("CELL must equal the glyph ROM edge of %0d", sudoku_pkg::CELL);
    end
    if ((X0 + GRID_N * CELL - 1 > 159) || (Y0 + GRID_N * CELL - 1 > 119)) begin : g_bounds_check
        $error("grid origin X0=%0d Y0=%0d pushes the board off the 160x120 screen", X0, Y0);
    end

    state_t     state;
    draw_mode_t mode;
    logic [3:0] glyph;
    logic [7:0] ox;
    logic [6:0] oy;
    logic       last_d;
    logic [3:0] px;
    logic [3:0] py;
    logic       last;
    logic [6:0] cell_idx;
    logic       accept;
    logic       is_edit;
    logic       cell_given;
    logic       start_draw;
    logic       step;

    assign cmd_bus.cmd_ready = enable && (state == IDLE);
    assign accept     = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
    assign is_edit    = (cmd_bus.cmd_code <= CMD_DIGIT_MAX) || (cmd_bus.cmd_code == CMD_CLEAR);
    assign cell_idx   = 7'(int'(cur_row) * GRID_N + int'(cur_col));
    assign cell_given = given_mask[cell_idx];
    assign start_draw = accept && is_edit && !cell_given;
    assign step       = (state == FETCH) || (state == PLOT);
    assign busy       = (state != IDLE);

    // The ROM answers one cycle after its address, which is exactly when the
    // registered x/y for that pixel are on the bus, so colour passes straight through.
    assign colour = !plot ? 3'd0 : (mode == MODE_CLEAR) ? BG_COLOUR : rom_data;

    glyph_raster_counter u_raster (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_draw),
        .step     (step),
        .glyph    (glyph),
        .px       (px),
        .py       (py),
        .last     (last),
        .rom_addr (rom_addr)
    );

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mode    <= MODE_GLYPH;
            glyph   <= '0;
            ox      <= '0;
            oy      <= '0;
            last_d  <= 1'b0;
            cur_row <= '0;
            cur_col <= '0;
            x       <= '0;
            y       <= '0;
            plot    <= 1'b0;
            done    <= 1'b0;
            reject  <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_bus.cmd_code)
                            CMD_UP:    if (cur_row != 4'd0) cur_row <= cur_row - 4'd1;
                            CMD_DOWN:  if (cur_row != 4'(GRID_N - 1)) cur_row <= cur_row + 4'd1;
                            CMD_LEFT:  if (cur_col != 4'd0) cur_col <= cur_col - 4'd1;
                            CMD_RIGHT: if (cur_col != 4'(GRID_N - 1)) cur_col <= cur_col + 4'd1;
                            default: begin
                                if (is_edit && cell_given) begin
                                    reject <= 1'b1;
                                end else if (is_edit) begin
                                    mode   <= (cmd_bus.cmd_code == CMD_CLEAR) ? MODE_CLEAR : MODE_GLYPH;
                                    glyph  <= (cmd_bus.cmd_code == CMD_CLEAR) ? 4'd0 : cmd_bus.cmd_code;
                                    ox     <= 8'(X0 + int'(cur_col) * CELL);
                                    oy     <= 7'(Y0 + int'(cur_row) * CELL);
                                    last_d <= 1'b0;
                                    state  <= FETCH;
                                end
                            end
                        endcase
                    end
                end
                FETCH, PLOT: begin
                    // last_d marks that the pixel now on x/y is the final one of the cell.
                    if (state == PLOT && last_d) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        plot   <= 1'b1;
                        x      <= ox + {4'b0, px};
                        y      <= oy + {3'b0, py};
                        last_d <= last;
                        state  <= PLOT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_plot_sequencer.sv
// Self-checking bench for cell_plot_sequencer: directed scenarios plus random
// command streams, all checked against a cell-level cursor/draw model.
module tb_cell_plot_sequencer;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        enable     = 1'b1;
    logic [80:0] given_mask = '0;
    logic [2:0]  rom_data   = '0;
    logic [10:0] rom_addr;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;
    logic        reject;
    logic [3:0]  cur_row;
    logic [3:0]  cur_col;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: cursor position and the pixels captured from the last draw.
    int m_row = 0;
    int m_col = 0;
    int pix_x[121];
    int pix_y[121];
    int pix_c[121];
    int n_plot;

    cell_plot_sequencer_if bus ();

    cell_plot_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cmd_bus    (bus),
        .given_mask (given_mask),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .reject     (reject),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] rom_fn(input logic [10:0] a);
        logic [10:0] t;
        t = a * 11'd5 + (a >> 3);
        return t[2:0] ^ t[6:4];
    endfunction

    // Synchronous glyph ROM: data follows the address by one clock.
    always @(posedge clock) rom_data <= rom_fn(rom_addr);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL accept: cmd_ready=%b, required 1 within 400 cycles", bus.cmd_ready);
        end
    endtask

    // Issue one command and check everything it should (and should not) cause.
    task automatic exec_cmd(input logic [3:0] code);
        bit ok, edit, rej, draw, clr;
        int glyph, span, done_cnt, done_cyc, rej_cnt, rej_cyc, busy_cnt, gap_err;
        int ex, ey, ec;
        edit  = (code <= 4'd8) || (code == 4'd13);
        rej   = edit && given_mask[m_row * 9 + m_col];
        draw  = edit && !rej;
        clr   = (code == 4'd13);
        glyph = clr ? 0 : int'(code);
        span  = draw ? 124 : 3;
        done_cnt = 0; done_cyc = 0; rej_cnt = 0; rej_cyc = 0; busy_cnt = 0; gap_err = 0;
        n_plot = 0;
        for (int k = 0; k < 121; k++) begin
            pix_x[k] = -1; pix_y[k] = -1; pix_c[k] = -1;
        end

        @(posedge clock); #1;
        bus.cmd_code  = code;
        bus.cmd_valid = 1'b1;
        wait_accept(ok);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        if (!ok) return;

        for (int cyc = 1; cyc <= span; cyc++) begin
            @(negedge clock);
            if (plot === 1'b1) begin
                if (n_plot < 121) begin
                    pix_x[n_plot] = int'(x);
                    pix_y[n_plot] = int'(y);
                    pix_c[n_plot] = int'(colour);
                end
                if (cyc != n_plot + 2) gap_err++;
                n_plot++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (reject === 1'b1) begin rej_cnt++; rej_cyc = cyc; end
            if (busy === 1'b1) busy_cnt++;
            if (draw && !clr && cyc == 1) begin
                vectors++;
                if (rom_addr !== 11'(glyph * 121)) begin
                    miscompares++;
                    $display("FAIL fetch_addr: rom_addr=%0d, required %0d", rom_addr, glyph * 121);
                end
            end
            if (draw && cyc == 124) begin
                vectors++;
                if (bus.cmd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_draw: cmd_ready=%b at cycle 124, required 1", bus.cmd_ready);
                end
            end
        end

        case (code)
            4'd9:  if (m_row > 0) m_row--;
            4'd10: if (m_row < 8) m_row++;
            4'd11: if (m_col > 0) m_col--;
            4'd12: if (m_col < 8) m_col++;
            default: ;
        endcase

        vectors++;
        if (n_plot != (draw ? 121 : 0)) begin
            miscompares++;
            $display("FAIL plot_count code %0d: %0d plot cycles, required %0d", code, n_plot, draw ? 121 : 0);
        end
        vectors++;
        if (gap_err != 0) begin
            miscompares++;
            $display("FAIL plot_timing code %0d: %0d plots off the cycle 2..122 window, required 0", code, gap_err);
        end
        if (draw) begin
            for (int k = 0; k < 121; k++) begin
                ex = 8 + m_col * 11 + k % 11;
                ey = 8 + m_row * 11 + k / 11;
                ec = clr ? 7 : int'(rom_fn(11'(glyph * 121 + k)));
                vectors++;
                if (pix_x[k] != ex || pix_y[k] != ey || pix_c[k] != ec) begin
                    miscompares++;
                    $display("FAIL pixel %0d: x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             k, pix_x[k], pix_y[k], pix_c[k], ex, ey, ec);
                end
            end
        end
        vectors++;
        if (done_cnt != (draw ? 1 : 0) || (draw && done_cyc != 123)) begin
            miscompares++;
            $display("FAIL done code %0d: %0d pulses last at cycle %0d, required %0d at 123", code, done_cnt, done_cyc, draw ? 1 : 0);
        end
        vectors++;
        if (rej_cnt != (rej ? 1 : 0) || (rej && rej_cyc != 1)) begin
            miscompares++;
            $display("FAIL reject code %0d: %0d pulses last at cycle %0d, required %0d at 1", code, rej_cnt, rej_cyc, rej ? 1 : 0);
        end
        vectors++;
        if (busy_cnt != (draw ? 123 : 0)) begin
            miscompares++;
            $display("FAIL busy code %0d: high for %0d cycles, required %0d", code, busy_cnt, draw ? 123 : 0);
        end
        vectors++;
        if (cur_row !== 4'(m_row) || cur_col !== 4'(m_col)) begin
            miscompares++;
            $display("FAIL cursor code %0d: (%0d,%0d), required (%0d,%0d)", code, cur_row, cur_col, m_row, m_col);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({plot, done, reject, busy} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: plot/done/reject/busy=%b, required 0000", {plot, done, reject, busy});
        end
        vectors++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || rom_addr !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_bus: x=%0d y=%0d colour=%0d rom_addr=%0d, required all 0", x, y, colour, rom_addr);
        end
        vectors++;
        if (cur_row !== 4'd0 || cur_col !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cur_row, cur_col);
        end
        reset = 1'b0;
        m_row = 0;
        m_col = 0;
        @(negedge clock);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: cmd_ready=%b after reset with enable=1, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_moves;
        int exp_col;
        @(posedge clock); #1;
        bus.cmd_code  = 4'd12;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            exp_col = (i > 8) ? 8 : i;
            vectors++;
            if (bus.cmd_ready !== 1'b1 || cur_col !== 4'(exp_col) || plot !== 1'b0) begin
                miscompares++;
                $display("FAIL right_held %0d: ready=%b cur_col=%0d plot=%b, required 1/%0d/0",
                         i, bus.cmd_ready, cur_col, plot, exp_col);
            end
        end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        m_col = 8;
        @(negedge clock);
        vectors++;
        if (cur_col !== 4'd8) begin
            miscompares++;
            $display("FAIL right_clamp: cur_col=%0d, required 8", cur_col);
        end
        exec_cmd(4'd9);
        exec_cmd(4'd14);
        exec_cmd(4'd15);
    endtask

    task automatic test_digit_draw;
        given_mask = '0;
        exec_cmd(4'd10);
        exec_cmd(4'd10);
        repeat (5) exec_cmd(4'd11);
        exec_cmd(4'd4);
        vectors++;
        if (pix_x[0] != 41 || pix_y[0] != 30 || pix_x[120] != 51 || pix_y[120] != 40) begin
            miscompares++;
            $display("FAIL digit_corners: first (%0d,%0d) last (%0d,%0d), required (41,30) and (51,40)",
                     pix_x[0], pix_y[0], pix_x[120], pix_y[120]);
        end
    endtask

    task automatic test_reject;
        given_mask = '0;
        given_mask[21] = 1'b1;
        exec_cmd(4'd0);
        exec_cmd(4'd13);
        given_mask = '0;
    endtask

    task automatic test_clear_corner;
        given_mask = {17'($urandom), $urandom, $urandom};
        given_mask[80] = 1'b0;
        repeat (6) exec_cmd(4'd10);
        repeat (5) exec_cmd(4'd12);
        exec_cmd(4'd13);
        vectors++;
        if (pix_x[0] != 96 || pix_y[0] != 96 || pix_x[120] != 106 || pix_y[120] != 106) begin
            miscompares++;
            $display("FAIL clear_range: first (%0d,%0d) last (%0d,%0d), required (96,96) and (106,106)",
                     pix_x[0], pix_y[0], pix_x[120], pix_y[120]);
        end
        given_mask = '0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int early_ready, moved, plots;
        early_ready = 0; moved = 0; plots = 0;
        @(posedge clock); #1;
        bus.cmd_code  = 4'd2;
        bus.cmd_valid = 1'b1;
        wait_accept(ok);
        @(posedge clock); #1;
        bus.cmd_code = 4'd11;
        for (int cyc = 1; cyc <= 124; cyc++) begin
            @(negedge clock);
            if (cyc <= 123 && bus.cmd_ready !== 1'b0) early_ready++;
            if (cur_col !== 4'(m_col)) moved++;
            if (plot === 1'b1) plots++;
        end
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL held_ready: cmd_ready=%b at cycle 124, required 1", bus.cmd_ready);
        end
        vectors++;
        if (early_ready != 0 || moved != 0 || plots != 121) begin
            miscompares++;
            $display("FAIL held_during_draw: early_ready=%0d moved=%0d plots=%0d, required 0/0/121",
                     early_ready, moved, plots);
        end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        if (m_col > 0) m_col--;
        @(negedge clock);
        vectors++;
        if (cur_col !== 4'(m_col)) begin
            miscompares++;
            $display("FAIL held_move: cur_col=%0d, required %0d", cur_col, m_col);
        end
    endtask

    task automatic test_random;
        logic [3:0] code;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) given_mask = {17'($urandom), $urandom, $urandom};
            code = 4'($urandom_range(0, 15));
            exec_cmd(code);
        end
        given_mask = '0;
    endtask

    task automatic test_reset_mid_draw;
        bit ok;
        int stray;
        stray = 0;
        given_mask = '0;
        @(posedge clock); #1;
        bus.cmd_code  = 4'd8;
        bus.cmd_valid = 1'b1;
        wait_accept(ok);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        repeat (60) @(negedge clock);
        vectors++;
        if (plot !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_draw_plot: plot=%b at cycle 60, required 1", plot);
        end
        reset = 1'b1;
        m_row = 0;
        m_col = 0;
        #1;
        vectors++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cur_row !== 4'd0 || cur_col !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: plot=%b busy=%b done=%b cursor (%0d,%0d), required 0/0/0 (0,0)",
                     plot, busy, done, cur_row, cur_col);
        end
        repeat (3) begin
            @(negedge clock);
            if (plot !== 1'b0) stray++;
        end
        reset = 1'b0;
        enable = 1'b0;
        bus.cmd_code  = 4'd12;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (plot !== 1'b0 || bus.cmd_ready !== 1'b0 || cur_col !== 4'd0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL after_reset_disabled: %0d cycles with plot, cmd_ready or cursor movement, required 0", stray);
        end
        bus.cmd_valid = 1'b0;
        enable = 1'b1;
        exec_cmd(4'd12);
    endtask

    initial begin
        test_reset();
        test_moves();
        test_digit_draw();
        test_reject();
        test_clear_corner();
        test_back_to_back();
        test_random();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cell_plot_sequencer.md
Name: cell_plot_sequencer

Overview:
- Sequences the VGA write port for the Sudoku play phase.
- Accepts decoded keyboard commands (digit 1-9, cursor move, cell clear) over a valid/ready handshake.
- Tracks the cursor cell and rejects writes to puzzle-given cells.
- Streams one 11x11 glyph (or background fill) into the selected cell: it walks the glyph ROM and drives x/y/colour/plot to the VGA adapter.
- Sits between the game control FSM (which supplies the key decode and draw-mode enable) and the VGA adapter/glyph ROM.

Parameters:
X0, 8, pixel x of grid cell (0,0) origin
Y0, 8, pixel y of grid cell (0,0) origin
CELL, 11, cell pitch and glyph edge in pixels
BG_COLOUR, 3'b111, colour used by clear command

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  draw mode active (from control FSM); when low, commands are not accepted
cmd_valid  in  1  command present
cmd_code  in  4  0-8 = digit 1-9, 9 = up, 10 = down, 11 = left, 12 = right, 13 = clear, 14-15 = no-op
cmd_ready  out  1  command accepted this cycle when valid&ready
given_mask  in  81  bit r*9+c set = cell (r,c) is a fixed puzzle cell
rom_addr  out  11  glyph ROM address = digit*121 + py*11 + px
rom_data  in  3  glyph ROM colour, valid one cycle after rom_addr
x  out  8  VGA pixel x
y  out  7  VGA pixel y
colour  out  3  VGA pixel colour
plot  out  1  VGA write enable
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse at end of a cell draw
reject  out  1  one-cycle pulse: digit or clear aimed at a given cell
cur_row  out  4  cursor row 0-8
cur_col  out  4  cursor column 0-8

Behaviour:
- Clock and reset: single clock `clock`; `reset` is asynchronous, active-high.
- Reset values: state IDLE; cur_row = cur_col = 0; plot, done, reject, busy = 0; x, y, colour, rom_addr = 0.
- Reset mid-draw aborts immediately. plot drops asynchronously and no further pixels are written.
- cmd_ready = enable & (state == IDLE). A command is accepted only on cycle valid&ready.
- Moves:
  - Accepted in 1 cycle; cursor updates on the next edge; state stays IDLE.
  - Clamp at the edges: up at row 0, down at row 8, left at col 0 and right at col 8 leave the cursor unchanged. No wrap.
- No-op codes 14-15: accepted, no effect.
- Digit or clear on a cell with given_mask[cur_row*9+cur_col] = 1:
  - Accepted, reject pulses on the next cycle, no draw, stays IDLE.
- Digit or clear on a free cell:
  - Latch glyph index and mode; compute the origin:
    - ox = X0 + cur_col*CELL (8-bit)
    - oy = Y0 + cur_row*CELL (7-bit)
  - Go to FETCH, then PLOT.
- States:
  - IDLE -> FETCH -> PLOT -> DONE -> IDLE.
  - FETCH: one cycle; issues rom_addr for pixel (0,0).
  - PLOT: each cycle issues the address for the next pixel and writes the previous pixel. plot = 1; x = ox+px_d; y = oy+py_d; colour = rom_data (or BG_COLOUR for clear); px/py delayed one cycle.
  - Pixel order is raster: px 0..10 inner, py 0..10 outer.
  - DONE: one cycle; done = 1, plot = 0.
- Latency, with acceptance edge = cycle 0:
  - FETCH at cycle 1.
  - First plot at cycle 2; last (121st) plot at cycle 122.
  - done at cycle 123; cmd_ready high again at cycle 124.
- Exactly 121 plot cycles per draw, contiguous.
- Clear mode: rom_addr still sequences, but colour is forced to BG_COLOUR.
- Cursor does not change during a draw. Moves arriving while busy are held off by cmd_ready = 0 and are not lost if cmd_valid is held.
- enable falling mid-draw: the draw completes; new commands are blocked afterwards.
- Arithmetic: rom_addr = glyph*121 + py*11 + px, computed at 11 bits; maximum 1088.
- Bounds: max x = X0+98 ≤ 159 and max y = Y0+98 ≤ 119 must hold for the chosen parameters; the implementation checks this at elaboration.

Decomposition:
- Shared package sudoku_pkg:
  - command code constants (CMD_DIGIT_MAX=8, CMD_UP=9, CMD_DOWN=10, CMD_LEFT=11, CMD_RIGHT=12, CMD_CLEAR=13)
  - grid constants (GRID_N=9, CELL=11, GLYPH_PIXELS=121)
  - state enum (IDLE, FETCH, PLOT, DONE)
- One sub-module, glyph_raster_counter: the px/py 0..10 counter pair, with last-pixel flag and rom_addr generation.
- Cursor and handshake logic stay in the top.

Test Plan:
- Reset, then hold cmd_code=12 valid for 10 accepts -> cur_col goes 1..8 and stays 8; cmd_code=9 at row 0 -> cur_row stays 0; no plot.
- Cursor (2,3), given_mask=0, cmd_code=4 (digit 5) -> 121 consecutive plot cycles starting cycle 2.
  - First pixel x=41, y=30, rom_addr=484; last x=51, y=40.
  - done at cycle 123.
- Cursor (2,3) with given_mask bit 21 set, cmd_code=0 -> reject pulse one cycle after accept, zero plot cycles, busy stays 0.
- cmd_code=13 at cursor (8,8) -> 121 plots with colour=3'b111; x range 96-106, y range 96-106.
- Move command presented during a draw with cmd_valid held -> cmd_ready low until cycle 124, then accepted; cursor moves only after done.
- Assert reset at cycle 60 of a draw -> plot=0 immediately, state IDLE, cursor (0,0); enable=0 with cmd_valid=1 -> cmd_ready stays 0.
